// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter: FSM encoding, operation codes
// and the default datapath width.
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_arbiter_rr_pick2.sv
// Two-way round-robin selector. gnt = 0 selects requester 0, 1 selects requester 1;
// the pointer rr only matters when both requesters are valid.
module rr_pick2 (
    input  logic v0,
    input  logic v1,
    input  logic rr,
    output logic gnt,
    output logic any
);

    assign gnt = (v0 && v1) ? rr : v1;
    assign any = v0 | v1;

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one external subtract/add unit between two requesters: IDLE accepts a request,
// ISSUE lets the unit settle and captures its result, RESP holds it until consumed.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_sub,
    input  logic             req1_sub,
    input  logic             req0_bcin,
    input  logic             req1_bcin,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_bcout,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_bcin,
    output logic             au_sub_add,
    input  logic [WIDTH-1:0] au_d_s,
    input  logic             au_bcout,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // reqN_ready is combinational from reqN_valid in IDLE; rspN_valid is registered and
    // held together with rsp_result/rsp_bcout until rspN_ready is seen.

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_bcin;
    logic [WIDTH-1:0] r_result;
    logic             r_bcout;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;

    logic             w_gnt;
    logic             w_any;
    logic             w_accept;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_rsp_hs;

    rr_pick2 u_pick (
        .v0  (req0_valid),
        .v1  (req1_valid),
        .rr  (r_rr),
        .gnt (w_gnt),
        .any (w_any)
    );

    assign w_rsp_hs = r_owner ? (r_rsp1_valid && rsp1_ready)
                              : (r_rsp0_valid && rsp0_ready);

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_gnt;
                    w_req1_ready = w_gnt;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_rsp_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= OP_ADD;
            r_bcin       <= 1'b0;
            r_result     <= '0;
            r_bcout      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_gnt;
                r_a     <= w_gnt ? req1_a    : req0_a;
                r_b     <= w_gnt ? req1_b    : req0_b;
                r_sub   <= w_gnt ? req1_sub  : req0_sub;
                r_bcin  <= w_gnt ? req1_bcin : req0_bcin;
            end
            if (r_state == S_ISSUE) begin
                r_result     <= au_d_s;
                r_bcout      <= au_bcout;
                r_rsp0_valid <= ~r_owner;
                r_rsp1_valid <= r_owner;
            end
            if (r_state == S_RESP && w_rsp_hs) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
                r_rr         <= ~r_owner;
            end
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_result = r_result;
    assign rsp_bcout  = r_bcout;
    assign au_a       = r_a;
    assign au_b       = r_b;
    assign au_bcin    = r_bcin;
    assign au_sub_add = r_sub;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural model of the shared add/sub unit.
module tb_addsub_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_sub, req1_sub, req0_bcin, req1_bcin;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_bcout;
    logic [W-1:0] au_a, au_b;
    logic         au_bcin, au_sub_add;
    logic [W-1:0] au_d_s;
    logic         au_bcout;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .req0_bcin(req0_bcin), .req1_bcin(req1_bcin),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_bcout(rsp_bcout),
        .au_a(au_a), .au_b(au_b), .au_bcin(au_bcin), .au_sub_add(au_sub_add),
        .au_d_s(au_d_s), .au_bcout(au_bcout),
        .dbg_state(dbg_state)
    );

    // External shared unit: add = A+B+cin, subtract = A-B-bin with bcout as borrow.
    logic [W:0] fa_sum;
    always_comb begin
        fa_sum = '0;
        if (au_sub_add) fa_sum = {1'b0, au_a} - {1'b0, au_b} - {{W{1'b0}}, au_bcin};
        else            fa_sum = {1'b0, au_a} + {1'b0, au_b} + {{W{1'b0}}, au_bcin};
    end
    assign au_d_s   = fa_sum[W-1:0];
    assign au_bcout = fa_sum[W];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_sub = 0; req1_sub = 0; req0_bcin = 0; req1_bcin = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic drive_req(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub, input logic bcin);
        if (port == 0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; req0_bcin = bcin;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; req1_bcin = bcin;
        end
    endtask

    // One isolated operation with rspN_ready high: accept in cycle 0, response in cycle 2.
    task automatic do_op(input string tag, input int port, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub, input logic bcin,
                         input logic [W-1:0] exp_res, input logic exp_bc);
        logic [1:0] rdy, vld, exp_sel;
        exp_sel = (port == 0) ? 2'b01 : 2'b10;
        drive_req(port, a, b, sub, bcin);
        #1;
        rdy = {req1_ready, req0_ready};
        check({tag, "_accept"}, {30'd0, rdy}, {30'd0, exp_sel});
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        vld = {rsp1_valid, rsp0_valid};
        check({tag, "_issue_novalid"}, {30'd0, vld}, 32'd0);
        check({tag, "_au_a"}, {24'd0, au_a}, {24'd0, a});
        tick();
        #1;
        vld = {rsp1_valid, rsp0_valid};
        check({tag, "_rsp_valid"}, {30'd0, vld}, {30'd0, exp_sel});
        check({tag, "_result"}, {24'd0, rsp_result}, {24'd0, exp_res});
        check({tag, "_bcout"}, {31'd0, rsp_bcout}, {31'd0, exp_bc});
        tick();
        vld = {rsp1_valid, rsp0_valid};
        check({tag, "_rsp_done"}, {30'd0, vld}, 32'd0);
    endtask

    initial begin
        logic [1:0]   rdy;
        logic [1:0]   exp_rdy;
        logic [W-1:0] held;
        int           waited;
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst_n = 0;
        #1;
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst_result", {23'd0, rsp_bcout, rsp_result}, 32'd0);
        check("rst_au", {14'd0, au_a, au_b, au_bcin, au_sub_add}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst_n = 1;
        tick();

        do_op("add",   0, 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0);
        do_op("wrap",  1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("sub",   0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b0);
        do_op("borrow", 0, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1);
        do_op("addc",  1, 8'h7F, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1);

        // Contention from a fresh reset: grants 0,1,0,1 three cycles apart.
        do_reset();
        drive_req(0, 8'h01, 8'h02, 1'b0, 1'b0);
        drive_req(1, 8'h03, 8'h04, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            rdy = {req1_ready, req0_ready};
            if (c % 3 == 0) exp_rdy = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else            exp_rdy = 2'b00;
            check($sformatf("contend_c%0d", c), {30'd0, rdy}, {30'd0, exp_rdy});
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Backpressure: req0 result held while req1 waits.
        do_reset();
        rsp0_ready = 0;
        drive_req(0, 8'h21, 8'h12, 1'b0, 1'b0);
        tick();
        req0_valid = 0;
        drive_req(1, 8'h05, 8'h03, 1'b1, 1'b0);
        tick();
        held = rsp_result;
        check("bp_result", {24'd0, held}, 32'h33);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_hold_%0d", c),
                  {20'd0, req1_ready, rsp1_valid, rsp0_valid, rsp_bcout, rsp_result},
                  {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, held});
            tick();
        end
        rsp0_ready = 1;
        tick();
        #1;
        check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        waited = 0;
        while (!rsp1_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("bp_rsp1_timeout", {31'd0, rsp1_valid}, 32'd1);
        check("bp_rsp1_result", {24'd0, rsp_result}, 32'h02);
        idle_inputs();
        tick();

        // Reset mid-operation: req0 completes (rr -> 1), req1 is cut off in ISSUE.
        do_reset();
        do_op("pre", 0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
        drive_req(1, 8'hAA, 8'h55, 1'b1, 1'b1);
        tick();
        idle_inputs();
        check("mid_state_issue", {30'd0, dbg_state}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_outs", {12'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid,
                               rsp_bcout, rsp_result, au_bcin, au_sub_add},
              32'd0);
        check("mid_rst_au", {16'd0, au_a, au_b}, 32'd0);
        tick();
        rst_n = 1;
        tick();
        tick();
        check("mid_no_stale", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        drive_req(0, 8'h01, 8'h00, 1'b0, 1'b0);
        drive_req(1, 8'h02, 8'h00, 1'b0, 1'b0);
        #1;
        check("mid_rr_reset", {30'd0, req1_ready, req0_ready}, 32'd1);
        idle_inputs();
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
